// File: rtl/keccak_arbiter.sv
// Two-requester round-robin arbiter in front of a shared Keccak core.
// Routes the seed words and output words of the granted sampler; the other side is masked.
module keccak_arbiter #(
    parameter int DATA_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [1:0]           mode0,
    input  logic [1:0]           mode1,
    input  logic [DATA_SIZE-1:0] din0,
    input  logic [DATA_SIZE-1:0] din1,
    input  logic                 din_valid0,
    input  logic                 din_valid1,
    input  logic                 din_last0,
    input  logic                 din_last1,
    input  logic                 rd0,
    input  logic                 rd1,
    input  logic                 done0,
    input  logic                 done1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 din_ack0,
    output logic                 din_ack1,
    output logic [DATA_SIZE-1:0] dout,
    output logic                 dout_valid0,
    output logic                 dout_valid1,
    output logic                 k_start_calc,
    output logic                 k_in_valid,
    output logic                 k_is_last,
    output logic                 k_gimme,
    output logic [1:0]           k_mode,
    output logic [DATA_SIZE-1:0] k_in,
    input  logic                 k_ack,
    input  logic                 k_out_ready,
    input  logic                 k_out_buf_empty,
    input  logic [DATA_SIZE-1:0] k_out
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        ABSORB,
        SQUEEZE,
        DRAIN
    } state_t;

    state_t     state_q;
    logic [1:0] gnt_q;
    logic       owner_q;
    logic       last_q;
    logic [1:0] mode_q;

    logic                 win_d;
    logic [DATA_SIZE-1:0] din_g;
    logic                 dv_g;
    logic                 dl_g;
    logic                 rd_g;
    logic                 done_g;
    logic                 unused_ready;

    assign unused_ready = k_out_ready;

    // Tie goes to whoever was not served last; a lone request always wins.
    always_comb begin
        win_d = req1;
        if (req0 && req1) begin
            win_d = ~last_q;
        end
    end

    always_comb begin
        din_g  = owner_q ? din1 : din0;
        dv_g   = owner_q ? din_valid1 : din_valid0;
        dl_g   = owner_q ? din_last1 : din_last0;
        rd_g   = owner_q ? rd1 : rd0;
        done_g = owner_q ? done1 : done0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            mode_q  <= 2'b00;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        owner_q <= win_d;
                        gnt_q   <= win_d ? 2'b10 : 2'b01;
                        mode_q  <= win_d ? mode1 : mode0;
                        state_q <= START;
                    end
                end
                START: begin
                    state_q <= ABSORB;
                end
                ABSORB: begin
                    // A release beats the final-word handoff in the same cycle.
                    if (done_g) begin
                        state_q <= DRAIN;
                    end else if (dv_g && dl_g && k_ack) begin
                        state_q <= SQUEEZE;
                    end
                end
                SQUEEZE: begin
                    if (done_g) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (k_out_buf_empty) begin
                        state_q <= IDLE;
                        gnt_q   <= 2'b00;
                        last_q  <= owner_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 2'b00;
                end
            endcase
        end
    end

    assign gnt0 = gnt_q[0];
    assign gnt1 = gnt_q[1];

    always_comb begin
        din_ack0     = 1'b0;
        din_ack1     = 1'b0;
        dout_valid0  = 1'b0;
        dout_valid1  = 1'b0;
        dout         = '0;
        k_start_calc = 1'b0;
        k_in_valid   = 1'b0;
        k_is_last    = 1'b0;
        k_gimme      = 1'b0;
        k_in         = '0;
        k_mode       = (state_q == IDLE) ? 2'b00 : mode_q;
        unique case (state_q)
            START: begin
                k_start_calc = 1'b1;
            end
            ABSORB: begin
                k_in       = din_g;
                k_in_valid = dv_g;
                k_is_last  = dv_g & dl_g;
                din_ack0   = ~owner_q & k_ack & dv_g;
                din_ack1   = owner_q & k_ack & dv_g;
            end
            SQUEEZE: begin
                k_gimme     = rd_g;
                dout        = k_out;
                dout_valid0 = ~owner_q & ~k_out_buf_empty;
                dout_valid1 = owner_q & ~k_out_buf_empty;
            end
            DRAIN: begin
                // Flush leftovers without ever kicking off a fresh squeeze.
                k_gimme = ~k_out_buf_empty;
            end
            default: begin
                k_in = '0;
            end
        endcase
    end

endmodule

// File: doc/keccak_arbiter.md
KECCAK_ARBITER -- requirements
Module: keccak_arbiter

Interface
REQ-001 Parameter: DATA_SIZE, 64, width of seed and output words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req0, req1  input  1 each  requester i wants the Keccak core (0 = parse sampler, 1 = CBD sampler).
REQ-005 mode0, mode1  input  2 each  Keccak mode requested by requester i.
REQ-006 din0, din1  input  DATA_SIZE each  seed word from requester i.
REQ-007 din_valid0, din_valid1  input  1 each  seed word valid.
REQ-008 din_last0, din_last1  input  1 each  marks the final seed word.
REQ-009 rd0, rd1  input  1 each  requester i pops one output word.
REQ-010 done0, done1  input  1 each  requester i releases the core.
REQ-011 gnt0, gnt1  output  1 each  requester i owns the core; registered.
REQ-012 din_ack0, din_ack1  output  1 each  seed word accepted this cycle.
REQ-013 dout  output  DATA_SIZE  output word to the granted requester.
REQ-014 dout_valid0, dout_valid1  output  1 each  dout valid for requester i.
REQ-015 k_start_calc, k_in_valid, k_is_last, k_gimme  output  1 each  Keccak core controls.
REQ-016 k_mode  output  2  Keccak mode; k_in  output  DATA_SIZE  Keccak seed word.
REQ-017 k_ack, k_out_ready, k_out_buf_empty  input  1 each  Keccak core status; k_out  input  DATA_SIZE  Keccak output word.

Function
REQ-018 FSM states: IDLE, START, ABSORB, SQUEEZE, DRAIN; exactly one gnt high outside IDLE, none in IDLE.
REQ-019 IDLE: if any req is high, register the winner, set its gnt and enter START on the next edge.
REQ-020 Arbitration is round-robin: with both req high, grant the requester not served last; last_served resets to 1, so req0 wins the first tie.
REQ-021 START lasts exactly 1 cycle: k_start_calc=1, k_mode = latched mode of winner (latched on the IDLE->START edge); then ABSORB.
REQ-022 ABSORB: k_in=din_g, k_in_valid=din_valid_g, k_is_last=din_valid_g&din_last_g, din_ack_g=k_ack&din_valid_g.
REQ-023 ABSORB->SQUEEZE on the cycle where din_valid_g & din_last_g & k_ack are all high.
REQ-024 SQUEEZE: k_gimme=rd_g, dout=k_out, dout_valid_g=~k_out_buf_empty.
REQ-025 done_g high in ABSORB or SQUEEZE -> DRAIN next edge; done_g takes priority over the ABSORB->SQUEEZE exit in the same cycle.
REQ-026 DRAIN: k_gimme=~k_out_buf_empty, never asserted while empty (prevents a fresh squeeze); when k_out_buf_empty=1 -> IDLE, gnt cleared, last_served updated.
REQ-027 Non-granted requester: din_ack=0, dout_valid=0; its rd, din and done are ignored.
REQ-028 Dropping req while granted has no effect; only done releases.
REQ-029 k_mode holds the latched mode for the whole grant; k_start_calc is asserted only in START.
REQ-030 Outside their active state, all k_* controls are 0; k_in and dout are don't-care but driven (no X).

Reset
REQ-031 rst=1 at a clock edge -> state IDLE, gnt0=gnt1=0, last_served=1, latched mode=0, in any state including mid-ABSORB or mid-SQUEEZE.
REQ-032 During and after reset until a grant, all outputs are 0: din_ack, dout_valid, k_start_calc, k_in_valid, k_is_last, k_gimme, k_mode.
REQ-033 The Keccak core shares rst; no flush is sequenced after reset.

Verification
REQ-034 req0=req1=1 from reset -> gnt0=1 one cycle later, k_start_calc=1 for 1 cycle, k_mode=mode0; after done0 and drain, gnt1=1.
REQ-035 Grant 0, mode=2, 3 seed words with din_last on word 3, k_ack stalls word 2 for 2 cycles -> exactly 3 din_ack0 pulses; k_is_last only with word 3; SQUEEZE follows.
REQ-036 SQUEEZE, FIFO holding 5 words, rd0 on 2 of them, then done0 -> DRAIN asserts k_gimme for 3 cycles, then IDLE; k_gimme never high with k_out_buf_empty=1.
REQ-037 done1 in ABSORB before the last word -> DRAIN, then IDLE; k_is_last never asserted.
REQ-038 rst mid-SQUEEZE with dout_valid0=1 -> next cycle all outputs 0, state IDLE; subsequent req1 alone -> gnt1.
REQ-039 gnt1 active, rd0=1 and din_valid0=1 -> k_gimme unaffected, din_ack0=0, dout_valid0=0.
